// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clk out.
// Optional even-parity trailer bit when PIPO_PARITY_EN is defined.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef PIPO_PARITY_EN
    localparam int unsigned N = WIDTH + 1;
`else
    localparam int unsigned N = WIDTH;
`endif
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam int unsigned   OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic             r_frame_start;
    logic             r_done;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_valid_nxt;
    logic             w_start_nxt;
    logic             w_done_nxt;
    logic             w_bit_nxt;
`ifdef PIPO_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath and next-cycle output values
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
`ifdef PIPO_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
        w_ready  = (r_state == S_IDLE) || w_last;
        w_accept = load_valid && w_ready;

        if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
            w_shift_nxt = parallel_in;
`ifdef PIPO_PARITY_EN
            w_parity_nxt = ^parallel_in;
`endif
        end else if (w_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
`ifdef PIPO_PARITY_EN
            w_parity_nxt = 1'b0;
`endif
        end else if (r_state == S_SHIFT) begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                           : {1'b0, r_shift[WIDTH-1:1]};
        end

        w_valid_nxt = (w_state_nxt == S_SHIFT);
        w_start_nxt = w_valid_nxt && (w_cnt_nxt == '0);
        w_done_nxt  = w_valid_nxt && (w_cnt_nxt == LAST);
        w_bit_nxt   = w_valid_nxt && w_shift_nxt[OUT_IDX];
`ifdef PIPO_PARITY_EN
        // Trailer slot carries parity of the word as captured
        if (w_valid_nxt && (w_cnt_nxt == CW'(WIDTH))) begin
            w_bit_nxt = w_parity_nxt;
        end
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_shift        <= '0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_frame_start  <= 1'b0;
            r_done         <= 1'b0;
`ifdef PIPO_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_shift        <= w_shift_nxt;
            r_serial_out   <= w_bit_nxt;
            r_serial_valid <= w_valid_nxt;
            r_frame_start  <= w_start_nxt;
            r_done         <= w_done_nxt;
`ifdef PIPO_PARITY_EN
            r_parity       <= w_parity_nxt;
`endif
        end
    end

    assign load_ready   = w_ready;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign frame_start  = r_frame_start;
    assign done         = r_done;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances on shared inputs,
// checked every cycle against a queue-of-bits frame model.
module tb_piso_shift_tx;

`ifdef PIPO_PARITY_EN
    localparam int N = 9;
    localparam logic [15:0] SEQ_M_B5 = 16'h016B;
    localparam logic [15:0] SEQ_L_B5 = 16'h015B;
`else
    localparam int N = 8;
    localparam logic [15:0] SEQ_M_B5 = 16'h00B5;
    localparam logic [15:0] SEQ_L_B5 = 16'h00AD;
`endif
    localparam logic [9:0] IDLE_OBS = 10'b10000_10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic       rdy_m, so_m, sv_m, fs_m, dn_m;
    logic       rdy_l, so_l, sv_l, fs_l, dn_l;
    logic [9:0] w_obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_m),
        .parallel_in(parallel_in), .serial_out(so_m), .serial_valid(sv_m),
        .frame_start(fs_m), .done(dn_m)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_l),
        .parallel_in(parallel_in), .serial_out(so_l), .serial_valid(sv_l),
        .frame_start(fs_l), .done(dn_l)
    );

    assign w_obs = {rdy_m, sv_m, so_m, fs_m, dn_m, rdy_l, sv_l, so_l, fs_l, dn_l};

    // Reference: queue of bits still to appear; front entry is what is on the wire now
    typedef struct packed {
        logic bm;
        logic bl;
        logic st;
        logic dn;
    } ent_t;

    ent_t q[$];
    ent_t m_e;
    logic m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            m_acc = load_valid && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (m_acc) begin
                for (int k = 0; k < N; k++) begin
                    if (k < 8) begin
                        m_e.bm = parallel_in[7-k];
                        m_e.bl = parallel_in[k];
                    end else begin
                        m_e.bm = ^parallel_in;
                        m_e.bl = ^parallel_in;
                    end
                    m_e.st = (k == 0);
                    m_e.dn = (k == N - 1);
                    q.push_back(m_e);
                end
            end
        end
    end

    function automatic logic [9:0] get_exp();
        logic r;
        ent_t e;
        if (q.size() == 0) return IDLE_OBS;
        r = (q.size() <= 1);
        e = q[0];
        return {r, 1'b1, e.bm, e.st, e.dn, r, 1'b1, e.bl, e.st, e.dn};
    endfunction

    task automatic tick(input logic v, input logic [7:0] d);
        @(negedge clk);
        load_valid  = v;
        parallel_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (w_obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", w_obs, IDLE_OBS);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [15:0] cm = '0;
        logic [15:0] cl = '0;
        logic [9:0]  ex;
        for (int i = 0; i <= N; i++) begin
            tick(i == 0, 8'hB5);
            ex = get_exp();
            n_tests++;
            if (w_obs !== ex) begin
                n_fail++;
                $display("FAIL single_frame cyc=%0d got=%b want=%b", i, w_obs, ex);
            end
            if (i < N) begin
                cm = {cm[14:0], so_m};
                cl = {cl[14:0], so_l};
            end
        end
        n_tests++;
        if (cm !== SEQ_M_B5 || cl !== SEQ_L_B5) begin
            n_fail++;
            $display("FAIL bit_order got=%h/%h want=%h/%h", cm, cl, SEQ_M_B5, SEQ_L_B5);
        end
    endtask

    task automatic test_back_to_back();
        int n_valid = 0;
        int n_start = 0;
        int second_start = -1;
        logic [9:0] ex;
        tick(1'b1, 8'hB5);
        for (int i = 0; i < 2 * N; i++) begin
            ex = get_exp();
            n_tests++;
            if (w_obs !== ex) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, w_obs, ex);
            end
            if (sv_m === 1'b1) n_valid++;
            if (fs_m === 1'b1) begin
                n_start++;
                if (i > 0) second_start = i;
            end
            if (i == N - 1) tick(1'b1, 8'h3C);
            else if (i < 2 * N - 1) tick(1'b0, 8'h00);
        end
        n_tests++;
        if (n_valid != 2 * N || n_start != 2 || second_start != N) begin
            n_fail++;
            $display("FAIL b2b_contig got valid=%0d starts=%0d at=%0d want %0d/2/%0d",
                     n_valid, n_start, second_start, 2 * N, N);
        end
        tick(1'b0, 8'h00);
        n_tests++;
        if (w_obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL b2b_idle got=%b want=%b", w_obs, IDLE_OBS);
        end
    endtask

    task automatic test_hold_ignore();
        int ones = 0;
        logic [9:0] ex;
        tick(1'b1, 8'h00);
        for (int i = 0; i <= 2 * N; i++) begin
            ex = get_exp();
            n_tests++;
            if (w_obs !== ex) begin
                n_fail++;
                $display("FAIL hold_ignore cyc=%0d got=%b want=%b", i, w_obs, ex);
            end
            if (i < N && (so_m === 1'b1 || so_l === 1'b1)) ones++;
            if (i == N && fs_m !== 1'b1) ones += 100;
            if (i < 2 * N) tick(i < N, 8'hFF);
        end
        n_tests++;
        if (ones != 0) begin
            n_fail++;
            $display("FAIL hold_first_frame got=%0d want=0", ones);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] ex;
        tick(1'b1, 8'hB5);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        reset = 1'b1;
        #1;
        n_tests++;
        if (w_obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL reset_mid got=%b want=%b", w_obs, IDLE_OBS);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i <= N; i++) begin
            tick(i == 0, 8'h3C);
            ex = get_exp();
            n_tests++;
            if (w_obs !== ex) begin
                n_fail++;
                $display("FAIL after_reset cyc=%0d got=%b want=%b", i, w_obs, ex);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] ex;
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), 8'($urandom));
            ex = get_exp();
            n_tests++;
            if (w_obs !== ex) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, w_obs, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold_ignore();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
